// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package ifetch_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  // Fetch addresses are word aligned; low bits of a redirect target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifetch_fifo.sv
// Synchronous FIFO of fetch entries with flush; head is read straight from storage.
module ifetch_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head,
  output logic [CW-1:0] count,
  output logic         empty,
  output logic         full
);

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push;
  logic          do_pop;

  function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
    return (32'(p) == DEPTH - 1) ? '0 : p + AW'(1);
  endfunction

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));
  assign count = cnt_q;
  assign head  = mem_q[rd_q];

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  always_comb begin
    mem_d   = mem_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_q] = wdata;
        wr_d        = bump(wr_q);
      end
      if (do_pop) begin
        rd_d = bump(rd_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ifetch.sv
// Instruction fetch front end: owns the fetch pc, issues in-order memory requests,
// buffers returned words for decode and discards responses made stale by redirects.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned MAX_OUT    = 2,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redir_valid,
  input  logic        redir_rel,
  input  logic [31:0] redir_pc,
  input  logic [31:0] redir_off,
  output logic        req_valid,
  input  logic        req_ready,
  output logic [31:0] req_addr,
  input  logic        rsp_valid,
  input  logic [31:0] rsp_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_inst
);

  localparam int unsigned BCW = $clog2(DEPTH + 1);
  localparam int unsigned QCW = $clog2(MAX_OUT + 1);

  fetch_state_t   state_q, state_d;
  logic [31:0]    faddr_q, faddr_d;
  logic [QCW-1:0] drop_q, drop_d;

  fetch_entry_t   buf_head, buf_wdata;
  logic [BCW-1:0] buf_cnt;
  logic           buf_empty, buf_full, buf_push, buf_pop;

  fetch_entry_t   infl_head, infl_wdata;
  logic [QCW-1:0] infl_cnt;
  logic           infl_empty, infl_full;

  logic           req_fire;
  logic [31:0]    redir_tgt;
  logic           unused_infl;

  // Credit check counts both in-flight and buffered words so a kept response always fits.
  assign req_valid = (state_q != IDLE) && !redir_valid && !infl_full &&
                     ((32'(infl_cnt) + 32'(buf_cnt)) < DEPTH);
  assign req_addr  = faddr_q;
  assign req_fire  = req_valid && req_ready;

  assign redir_tgt = redir_rel ? (redir_pc + redir_off) : redir_off;

  assign infl_wdata  = '{pc: faddr_q, inst: 32'h0};
  assign buf_wdata   = '{pc: infl_head.pc, inst: rsp_data};
  assign buf_push    = rsp_valid && !redir_valid && (drop_q == '0);
  assign buf_pop     = out_ready && !buf_empty && !redir_valid;
  assign unused_infl = ^infl_head.inst;

  assign out_valid = !buf_empty;
  assign out_pc    = buf_empty ? 32'h0 : buf_head.pc;
  assign out_inst  = buf_empty ? 32'h0 : buf_head.inst;

  always_comb begin
    state_d = state_q;
    faddr_d = faddr_q;
    drop_d  = drop_q;
    if (rsp_valid && (drop_q != '0)) begin
      drop_d = drop_q - QCW'(1);
    end
    if (req_fire) begin
      faddr_d = faddr_q + 32'(INST_BYTES);
    end
    // Every response still owed at a redirect is stale, including one arriving now.
    if (redir_valid) begin
      faddr_d = align_pc(redir_tgt);
      drop_d  = infl_cnt - QCW'(rsp_valid);
    end
    case (state_q)
      IDLE:    state_d = RUN;
      RUN:     if (redir_valid && (drop_d != '0)) state_d = DRAIN;
      DRAIN:   if (drop_d == '0) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      faddr_q <= RESET_ADDR;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      faddr_q <= faddr_d;
      drop_q  <= drop_d;
    end
  end

  ifetch_fifo #(.DEPTH(DEPTH)) u_ibuf (
    .clk   (clk),
    .rst   (rst),
    .push  (buf_push),
    .wdata (buf_wdata),
    .pop   (buf_pop),
    .flush (redir_valid),
    .head  (buf_head),
    .count (buf_cnt),
    .empty (buf_empty),
    .full  (buf_full)
  );

  // Pc of every issued request, matched in order with returning responses.
  ifetch_fifo #(.DEPTH(MAX_OUT)) u_inflight (
    .clk   (clk),
    .rst   (rst),
    .push  (req_fire),
    .wdata (infl_wdata),
    .pop   (rsp_valid),
    .flush (1'b0),
    .head  (infl_head),
    .count (infl_cnt),
    .empty (infl_empty),
    .full  (infl_full)
  );

  a_rsp_has_owner : assert property (@(posedge clk) disable iff (!rst)
    rsp_valid |-> !infl_empty);

  a_kept_rsp_fits : assert property (@(posedge clk) disable iff (!rst)
    buf_push |-> !buf_full);

endmodule

// File: tb/tb_ifetch.sv
// Randomized bench for ifetch: the bench plays instruction memory and checks the DUT
// against a request/epoch scoreboard of what decode should see.
module tb_ifetch;

  localparam int          DEPTH      = 4;
  localparam int          MAX_OUT    = 2;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redir_valid = 1'b0, redir_rel = 1'b0;
  logic [31:0] redir_pc = '0, redir_off = '0;
  logic        req_valid, req_ready = 1'b0;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_inst;

  always #5 clk = ~clk;

  ifetch #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT), .RESET_ADDR(RESET_ADDR)) dut (
    .clk(clk), .rst(rst),
    .redir_valid(redir_valid), .redir_rel(redir_rel),
    .redir_pc(redir_pc), .redir_off(redir_off),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst)
  );

  typedef struct {
    logic [31:0] addr;
    int unsigned epoch;
    int unsigned due;
  } pend_t;

  pend_t       pend[$];
  logic [31:0] fq[$];
  int unsigned epoch = 0;
  int unsigned cyc = 0;
  logic [31:0] exp_req = RESET_ADDR;
  bit          started = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redir_valid = 1'b0; redir_rel = 1'b0; redir_pc = '0; redir_off = '0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0; out_ready = 1'b0;
    #1;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_req_addr", req_addr, RESET_ADDR);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_inst", out_inst, 0);
    pend.delete();
    fq.delete();
    started = 1'b0;
    exp_req = RESET_ADDR;
    epoch++;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // One clock: drive at negedge, check, model the edge, return at next negedge.
  task automatic step(input int p_rr, input int p_or, input int p_rd, input int kmax,
                      output bit dut_fire);
    logic        exp_rv, kept;
    logic [31:0] tgt;
    pend_t       p;
    rsp_valid = 1'b0;
    rsp_data  = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rsp_valid = 1'b1;
      rsp_data  = memf(pend[0].addr);
    end
    req_ready   = ($urandom_range(99) < p_rr);
    out_ready   = ($urandom_range(99) < p_or);
    redir_valid = ($urandom_range(99) < p_rd);
    case ($urandom_range(4))
      0: begin redir_rel = 1'b0; redir_pc = $urandom; redir_off = 32'h0000_0100; end
      1: begin redir_rel = 1'b1; redir_pc = 32'h0000_0040; redir_off = 32'hFFFF_FFF0; end
      2: begin redir_rel = 1'b0; redir_pc = $urandom; redir_off = 32'h0000_0007; end
      3: begin redir_rel = 1'b0; redir_pc = $urandom; redir_off = 32'hFFFF_FFF8; end
      default: begin redir_rel = 1'($urandom_range(1)); redir_pc = $urandom; redir_off = $urandom; end
    endcase
    tgt = redir_rel ? (redir_pc + redir_off) : redir_off;
    #1;
    exp_rv = started && !redir_valid && (pend.size() < MAX_OUT) &&
             ((pend.size() + fq.size()) < DEPTH);
    chk("req_valid", req_valid, exp_rv);
    if (exp_rv) chk("req_addr", req_addr, exp_req);
    chk("out_valid", out_valid, fq.size() > 0);
    if (fq.size() > 0) begin
      chk("out_pc", out_pc, fq[0]);
      chk("out_inst", out_inst, memf(fq[0]));
    end
    dut_fire = req_valid && req_ready;
    @(posedge clk);
    kept = 1'b0;
    if (rsp_valid) begin
      p    = pend.pop_front();
      kept = (p.epoch == epoch) && !redir_valid;
    end
    if (redir_valid) begin
      fq.delete();
      epoch++;
      exp_req = {tgt[31:2], 2'b00};
    end else begin
      if (out_ready && fq.size() > 0) void'(fq.pop_front());
      if (kept) fq.push_back(p.addr);
      if (exp_rv && req_ready) begin
        p.addr  = exp_req;
        p.epoch = epoch;
        p.due   = cyc + $urandom_range(kmax, 1);
        pend.push_back(p);
        exp_req = exp_req + 32'd4;
      end
    end
    started = 1'b1;
    cyc++;
    @(negedge clk);
  endtask

  task automatic run(input int n, input int p_rr, input int p_or, input int p_rd,
                     input int kmax, output int fires);
    bit f;
    fires = 0;
    for (int i = 0; i < n; i++) begin
      step(p_rr, p_or, p_rd, kmax, f);
      if (f) fires++;
    end
  endtask

  initial begin
    int  fires;
    bit  f;
    #2;
    do_reset();
    run(24, 100, 100, 0, 1, fires);
    chk("steady_reqs", fires, 23);

    do_reset();
    run(12, 100, 0, 0, 1, fires);
    chk("stall_reqs", fires, DEPTH);
    run(12, 100, 100, 0, 1, fires);

    run(300, 70, 70, 8, 3, fires);
    run(300, 90, 90, 15, 1, fires);
    run(40, 100, 60, 20, 6, fires);

    for (int i = 0; i < 50 && pend.size() == 0; i++) step(100, 50, 0, 6, f);
    step(100, 50, 100, 6, f);
    do_reset();
    run(20, 100, 100, 0, 1, fires);
    run(300, 60, 60, 10, 4, fires);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch.md
Name: ifetch

Overview:
- Instruction fetch front end that consumes redirects from the branch/execute stage and produces a stream of (pc, instruction) pairs for decode.
- Owns the fetch address register.
- Issues in-order requests to instruction memory over a valid/ready interface.
- Buffers returned words in a small FIFO and discards stale responses after a redirect.

Parameters:
- DEPTH, 4, instruction buffer entries (power of two, >=2).
- MAX_OUT, 2, maximum outstanding memory requests (>=1, <=DEPTH).
- RESET_ADDR, 32'h0000_0000, first fetch address after reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- redir_valid  input  1  redirect request from execute, single-cycle pulse.
- redir_rel  input  1  1: target = redir_pc + redir_off; 0: target = redir_off.
- redir_pc  input  32  pc of the redirecting instruction.
- redir_off  input  32  offset or absolute target.
- req_valid  output  1  memory request valid.
- req_ready  input  1  memory accepts request.
- req_addr  output  32  request byte address.
- rsp_valid  input  1  response word valid; in order; always accepted.
- rsp_data  input  32  response instruction word.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  decode consumes head.
- out_pc  output  32  pc of head instruction.
- out_inst  output  32  head instruction word.

Behaviour:
- Reset (rst low, async):
  - faddr=RESET_ADDR, outstanding=0, drop_cnt=0, FIFO empty, state=IDLE.
  - req_valid=0, out_valid=0, out_pc/out_inst=0.
- FSM:
  - IDLE -> RUN unconditionally on the first clock after rst deasserts; no request is issued in IDLE.
  - RUN -> DRAIN on a redirect with surviving outstanding>0.
  - DRAIN -> RUN when drop_cnt reaches 0.
  - A redirect in DRAIN reloads drop_cnt.
- Request issue:
  - req_valid = state!=IDLE && !redir_valid && outstanding<MAX_OUT && (outstanding+fifo_count)<DEPTH.
  - req_addr=faddr.
  - On handshake: faddr<=faddr+4, modulo 2^32 (32'hFFFF_FFFC wraps to 0). Push faddr into the in-flight pc queue; outstanding+1.
  - req_valid and req_addr must hold stable while req_valid=1 and req_ready=0, unless a redirect arrives. A redirect withdraws the request the same cycle (req_valid=0).
- Response:
  - Every rsp_valid pops the in-flight pc queue and decrements outstanding.
  - If drop_cnt>0: discard the word, drop_cnt-1.
  - Otherwise write {pc, rsp_data} into the FIFO.
  - Credit rule guarantees the FIFO is never full on a kept response.
  - rsp_valid with outstanding==0 is a protocol violation (assertion).
- Redirect (redir_valid=1):
  - Target = redir_rel ? redir_pc+redir_off : redir_off, 32-bit wrap; loaded into faddr next edge.
  - FIFO flushed; out_valid=0 next cycle.
  - drop_cnt <= outstanding, minus 1 if rsp_valid is in the same cycle; that response is also discarded.
  - No request is issued in the redirect cycle.
- Simultaneous events:
  - Redirect wins over FIFO push/pop.
  - FIFO push+pop in the same cycle keeps the count.
  - out_ready with out_valid=0 is ignored.
- Latency:
  - Request handshake at cycle t, response at t+k (k>=1): out_valid at t+k+1, since FIFO storage is registered.
  - Redirect at cycle r: first request to the target at r+1.
- Steady state: with k=1 and MAX_OUT>=2, the block sustains 1 instruction/cycle when out_ready=1.
- Misaligned target: bits [1:0] are forced to 0 on load.

Decomposition:
- Package ifetch_pkg holds:
  - typedef fetch_entry_t {logic [31:0] pc; logic [31:0] inst;}.
  - Constant INST_BYTES=4.
  - Enum fetch_state_t {IDLE, RUN, DRAIN}.
- Sub-module ifetch_fifo: parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty and full.
  - Instantiated twice: instruction buffer (DEPTH) and in-flight pc queue (MAX_OUT).

Test Plan:
- Reset, then req_ready=1 and rsp after k=1 echoing the address, out_ready=1 -> req_addr 0,4,8,...; out_pc 0 with out_inst 32'h0 at cycle 3; one instruction/cycle thereafter.
- out_ready=0, req_ready=1 -> exactly DEPTH=4 requests issued (0..C); req_valid stays 0 until out_ready is raised.
- Two requests outstanding (0x10, 0x14), then redirect absolute 0x100 -> both responses dropped; out_valid=0; next req_addr=0x100; first out_pc=0x100.
- Relative redirect with redir_pc=0x40, redir_off=32'hFFFF_FFF0 -> next req_addr=0x30; redir_off=0x7 with rel=0 -> 0x4.
- faddr=32'hFFFF_FFFC -> next req_addr=0x0; out_pc sequence FFFF_FFFC, 0000_0000.
- Assert rst low mid-DRAIN with one request outstanding -> all outputs 0 immediately; after release, first req_addr=RESET_ADDR issued one cycle after IDLE.
